// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT definitions used by both the serial checker and the
// transmitter-side blocks: polynomial, widths, default preset and frame FSM states.
package crc16_pkg;

   localparam int              CRC_W            = 16;
   localparam logic [CRC_W-1:0] CRC_POLY         = 16'h1021;
   localparam logic [CRC_W-1:0] CRC_INIT_DEFAULT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CRC     = 2'd2,
      ST_DONE    = 2'd3
   } crc_state_t;

endpackage

// File: rtl/crc16_ccitt_step.sv
// One-bit MSB-first CRC-16/CCITT LFSR step, non-reflected, no output XOR.
module crc16_ccitt_step
   import crc16_pkg::*;
(
   input  logic [CRC_W-1:0] crc_in,
   input  logic             data_bit,
   output logic [CRC_W-1:0] crc_next
);

   logic fb;

   assign fb       = data_bit ^ crc_in[CRC_W-1];
   assign crc_next = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);

endmodule

// File: rtl/serial_crc_16_checker.sv
// Serial frame receiver: captures PAYLOAD_BITS payload bits MSB-first, runs the
// trailing 16 CRC bits through the same LFSR and flags a zero residue as crc_ok.
module serial_crc_16_checker
   import crc16_pkg::*;
#(
   parameter int              PAYLOAD_BITS = 32,
   parameter logic [CRC_W-1:0] CRC_INIT     = CRC_INIT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sof,
   input  logic                    bit_valid,
   input  logic                    data_in,
   output logic [PAYLOAD_BITS-1:0] payload_out,
   output logic                    frame_done,
   output logic                    crc_ok,
   output logic                    busy,
   output logic [CRC_W-1:0]        crc_out
);

   localparam int CW = $clog2(PAYLOAD_BITS + 16);
   localparam logic [CW-1:0] LAST_PAY = CW'(PAYLOAD_BITS - 1);
   localparam logic [CW-1:0] LAST_CRC = CW'(PAYLOAD_BITS + 15);

   // Handshake: a frame bit is transferred on every cycle with bit_valid=1;
   // there is no backpressure. sof only counts when bit_valid is also high.

   crc_state_t              state_q;
   logic [CW-1:0]           cnt_q;
   logic [CRC_W-1:0]        lfsr_q;
   logic                    start;
   logic [CW-1:0]           idx;
   logic [CRC_W-1:0]        crc_base;
   logic [CRC_W-1:0]        lfsr_step;
   logic [PAYLOAD_BITS-1:0] pay_next;

   assign start    = sof & bit_valid;
   // cnt_q is the frame index of the last accepted bit; sof lands on index 0
   assign idx      = start ? '0 : cnt_q + CW'(1);
   assign crc_base = start ? CRC_INIT : lfsr_q;
   assign crc_out  = lfsr_q;

   crc16_ccitt_step u_step (
      .crc_in   (crc_base),
      .data_bit (data_in),
      .crc_next (lfsr_step)
   );

   if (PAYLOAD_BITS > 1) begin : g_shift
      assign pay_next = {payload_out[PAYLOAD_BITS-2:0], data_in};
   end else begin : g_one
      assign pay_next = data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         lfsr_q      <= CRC_INIT;
         payload_out <= '0;
         frame_done  <= 1'b0;
         crc_ok      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (start) begin
            // sof wins in every state, including a restart during DONE
            lfsr_q      <= lfsr_step;
            cnt_q       <= '0;
            payload_out <= pay_next;
            busy        <= 1'b1;
            state_q     <= (PAYLOAD_BITS == 1) ? ST_CRC : ST_PAYLOAD;
         end else begin
            case (state_q)
               ST_IDLE: begin
               end
               ST_PAYLOAD: begin
                  if (bit_valid) begin
                     lfsr_q      <= lfsr_step;
                     cnt_q       <= idx;
                     payload_out <= pay_next;
                     if (idx == LAST_PAY) state_q <= ST_CRC;
                  end
               end
               ST_CRC: begin
                  if (bit_valid) begin
                     lfsr_q <= lfsr_step;
                     cnt_q  <= idx;
                     if (idx == LAST_CRC) begin
                        state_q    <= ST_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        crc_ok     <= (lfsr_step == '0);
                     end
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_crc_16_checker.sv
// Directed bench for serial_crc_16_checker with a 72-bit "123456789" payload.
module tb_serial_crc_16_checker;
   localparam int PB = 72;

   logic          clk;
   logic          rst_n;
   logic          sof;
   logic          bit_valid;
   logic          data_in;
   logic [PB-1:0] payload_out;
   logic          frame_done;
   logic          crc_ok;
   logic          busy;
   logic [15:0]   crc_out;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int base;

   localparam logic [PB-1:0] PAY  = 72'h313233343536373839;
   localparam logic [87:0]   GOOD = {72'h313233343536373839, 16'h29B1};
   localparam logic [87:0]   BAD  = {72'h313233343536373839, 16'h29B0};

   serial_crc_16_checker #(.PAYLOAD_BITS(PB), .CRC_INIT(16'hFFFF)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .sof         (sof),
      .bit_valid   (bit_valid),
      .data_in     (data_in),
      .payload_out (payload_out),
      .frame_done  (frame_done),
      .crc_ok      (crc_ok),
      .busy        (busy),
      .crc_out     (crc_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // frame_done sampled before the edge updates it: counts each pulse once
   always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers: inputs change at negedge, DUT samples at posedge
   task automatic send_bit(input logic b, input logic s);
      sof = s; bit_valid = 1'b1; data_in = b;
      @(negedge clk);
      sof = 1'b0; bit_valid = 1'b0; data_in = 1'b0;
   endtask

   task automatic send_range(input logic [87:0] v, input int lo, input int hi, input logic first_sof);
      for (int i = lo; i <= hi; i++) send_bit(v[87-i], first_sof && (i == lo));
   endtask

   task automatic send_gapped(input logic [87:0] v);
      int g0, g1, g2;
      g0 = $urandom_range(1, 29);
      g1 = $urandom_range(30, 59);
      g2 = $urandom_range(60, 87);
      for (int i = 0; i < 88; i++) begin
         if (i == g0 || i == g1 || i == g2) begin
            sof = 1'b1; bit_valid = 1'b0; data_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            sof = 1'b0; data_in = 1'b0;
         end
         send_bit(v[87-i], i == 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; sof = 1'b0; bit_valid = 1'b0; data_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_crc_ok", crc_ok, 0);
      check("rst_crc_out", crc_out, 16'hFFFF);
      check("rst_payload", payload_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // idle bits without sof, and sof without bit_valid, are ignored
      send_range(GOOD, 0, 4, 1'b0);
      sof = 1'b1; @(negedge clk); sof = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_crc_out", crc_out, 16'hFFFF);
      check("idle_payload", payload_out, 0);

      // good frame
      base = done_cnt;
      send_range(GOOD, 0, 71, 1'b1);
      check("good_crc_after_payload", crc_out, 16'h29B1);
      check("good_busy_mid", busy, 1);
      check("good_payload_mid", payload_out, PAY);
      send_range(GOOD, 72, 87, 1'b0);
      check("good_done_pulse", frame_done, 1);
      check("good_crc_ok", crc_ok, 1);
      check("good_residue", crc_out, 16'h0000);
      check("good_busy_done", busy, 0);
      check("good_payload", payload_out, PAY);
      @(negedge clk);
      check("good_done_low", frame_done, 0);
      check("good_done_count", done_cnt - base, 1);

      // bad CRC: residue of a one-bit error in the last CRC bit is x^16 mod g
      base = done_cnt;
      send_range(BAD, 0, 87, 1'b1);
      check("bad_done_pulse", frame_done, 1);
      check("bad_crc_ok", crc_ok, 0);
      check("bad_residue", crc_out, 16'h1021);
      @(negedge clk);
      check("bad_done_count", done_cnt - base, 1);

      // gaps with bit_valid low (sof held high in gaps, ignored)
      base = done_cnt;
      send_gapped(GOOD);
      check("gap_done_pulse", frame_done, 1);
      check("gap_crc_ok", crc_ok, 1);
      check("gap_payload", payload_out, PAY);
      @(negedge clk);
      check("gap_done_count", done_cnt - base, 1);

      // abort at payload bit 40 by a new sof, then full correct frame
      send_range(BAD, 0, 71, 1'b1);
      send_range(BAD, 72, 87, 1'b0);
      @(negedge clk);
      base = done_cnt;
      send_range(GOOD, 0, 39, 1'b1);
      send_range(GOOD, 0, 87, 1'b1);
      check("abort_crc_ok", crc_ok, 1);
      check("abort_payload", payload_out, PAY);
      @(negedge clk);
      check("abort_done_count", done_cnt - base, 1);

      // async reset at CRC bit 5
      base = done_cnt;
      send_range(GOOD, 0, 76, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_crc_ok", crc_ok, 0);
      check("mrst_crc_out", crc_out, 16'hFFFF);
      check("mrst_payload", payload_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_no_done", done_cnt - base, 0);
      send_range(GOOD, 0, 87, 1'b1);
      check("mrst_crc_ok_after", crc_ok, 1);
      @(negedge clk);
      check("mrst_done_count", done_cnt - base, 1);

      // back-to-back: second sof lands in the DONE cycle
      base = done_cnt;
      send_range(GOOD, 0, 87, 1'b1);
      check("b2b_first_pulse", frame_done, 1);
      check("b2b_first_ok", crc_ok, 1);
      send_range(BAD, 0, 87, 1'b1);
      check("b2b_second_pulse", frame_done, 1);
      check("b2b_second_ok", crc_ok, 0);
      @(negedge clk);
      check("b2b_done_count", done_cnt - base, 2);
      check("b2b_busy_end", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_crc_16_checker.md
SERIAL_CRC_16_CHECKER -- requirements
Module: serial_crc_16_checker

Interface
REQ-001 Parameter PAYLOAD_BITS, default 32, number of payload bits per frame (legal range 1..1024).
REQ-002 Parameter CRC_INIT, default 16'hFFFF, LFSR preset value at frame start.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low; asserting it (low) clears all state immediately, and release is synchronous to clk.
REQ-005 sof  input  1  start-of-frame strobe; qualifies the first bit of a new frame.
REQ-006 bit_valid  input  1  data_in carries a frame bit this cycle.
REQ-007 data_in  input  1  serial bit, MSB-first: payload, then the 16-bit CRC MSB-first.
REQ-008 payload_out  output  PAYLOAD_BITS  captured payload, MSB = first received bit.
REQ-009 frame_done  output  1  one-cycle pulse after the last CRC bit is accepted.
REQ-010 crc_ok  output  1  level; 1 iff the last completed frame had a zero residue.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 crc_out  output  16  live LFSR contents.

Function
REQ-013 The block SHALL use CCITT polynomial 0x1021, non-reflected, no output XOR; the per-bit update SHALL be fb = data_in ^ lfsr[15], lfsr = {lfsr[14:0],0} ^ (fb ? 16'h1021 : 0).
REQ-014 The FSM SHALL have states IDLE, PAYLOAD, CRC and DONE.
REQ-015 Transitions:
  - IDLE -> PAYLOAD on sof&bit_valid.
  - PAYLOAD -> CRC after PAYLOAD_BITS accepted bits.
  - CRC -> DONE after 16 accepted bits.
  - DONE -> IDLE unconditionally on the next cycle.
REQ-016 On sof&bit_valid the LFSR SHALL load CRC_INIT and process that same bit in the same cycle; that bit is counted as payload bit 0.
REQ-017 A bit SHALL be accepted only on cycles with bit_valid=1; with bit_valid=0, the LFSR, counter and payload register SHALL hold.
REQ-018 Payload bits SHALL shift into payload_out LSB-side (shift left); CRC bits SHALL update only the LFSR.
REQ-019 The bit counter SHALL be $clog2(PAYLOAD_BITS+16) bits wide and SHALL reset to 0 at each sof.
REQ-020 In DONE, frame_done SHALL pulse high for 1 cycle, and crc_ok SHALL update to (lfsr==16'h0000) in that same cycle; the latency is 1 clk after the final CRC bit is accepted.
REQ-021 crc_ok and payload_out SHALL hold their values until the next frame_done; mid-frame they SHALL not change except by payload shifting.
REQ-022 sof&bit_valid in PAYLOAD or CRC SHALL abort the current frame without a frame_done and restart per REQ-016 (sof has priority).
REQ-023 sof without bit_valid SHALL be ignored.
REQ-024 Bits arriving in IDLE without sof SHALL be ignored.
REQ-025 sof&bit_valid in DONE SHALL be accepted as the start of a new frame while frame_done still pulses for the old frame.
REQ-026 busy SHALL be 1 in PAYLOAD and CRC, and 0 in IDLE and DONE.

Reset
REQ-027 On reset low:
  - state = IDLE, counter = 0, lfsr = CRC_INIT, payload_out = 0;
  - frame_done = 0, crc_ok = 0, busy = 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame and produce no frame_done.

Structure
REQ-029 The polynomial 16'h1021, CRC_INIT default, CRC width 16 and the FSM state enum SHALL live in shared package crc16_pkg, which the transmitter-side blocks also use.
REQ-030 The LFSR update SHALL be one sub-module, crc16_ccitt_step (combinational: crc_in, bit -> crc_next), instantiated once.

Verification
REQ-031 PAYLOAD_BITS=72, payload ASCII "123456789" followed by CRC 16'h29B1 -> crc_out == 16'h29B1 after the payload, frame_done pulses once, crc_ok = 1, payload_out = 72'h313233343536373839.
REQ-032 Same frame with CRC 16'h29B0 -> frame_done pulses, crc_ok = 0, residue nonzero.
REQ-033 Same correct frame with bit_valid deasserted for 3 random cycles between bits -> identical result to REQ-031; frame_done is 1 cycle after the last valid bit.
REQ-034 Second sof at payload bit 40, then a full correct frame -> exactly one frame_done, crc_ok = 1.
REQ-035 reset low at CRC bit 5, released, then a correct frame -> outputs return to reset values immediately; a single frame_done with crc_ok = 1.
REQ-036 Back-to-back frames with the second sof in the DONE cycle (good, then bad) -> two frame_done pulses, crc_ok = 1 then 0.
